// File: rtl/uart_frame_parser.sv
// uart_frame_parser: turns the UART byte stream into framed records
//   FLAG, ADDR, LEN, LEN payload bytes, FLAG
// Each payload byte is emitted with the frame address. A frame then ends with a
// one-cycle frame_done pulse (good closing flag) or frame_error pulse (bad closing
// byte or inter-byte timeout). All outputs are registered.
module uart_frame_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter logic [7:0]  FLAG           = 8'h7E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_data_rx,
  input  logic [7:0] data_rx,
  output logic [7:0] address,
  output logic [7:0] data,
  output logic       data_valid,
  output logic [7:0] frame_len,
  output logic       frame_done,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_ENDF = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [BYTE_W-1:0]   address_q, address_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                data_valid_q, data_valid_d;
  logic [BYTE_W-1:0]   frame_len_q, frame_len_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_error_q, frame_error_d;
  logic                busy_q, busy_d;
  logic                timeout_hit_c;
  logic                is_flag_c;

  // A received byte always takes priority over an expiring timeout
  assign timeout_hit_c = (state_q != S_IDLE) && !new_data_rx &&
                         (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign is_flag_c     = (data_rx == FLAG);

  // Next-state, counter and output-register logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    address_d     = address_q;
    data_d        = data_q;
    frame_len_d   = frame_len_q;
    data_valid_d  = 1'b0;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;

    if (new_data_rx) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (is_flag_c) state_d = S_ADDR;
        end
        S_ADDR: begin
          // Repeated flags keep us waiting for the address (resync)
          if (!is_flag_c) begin
            address_d = data_rx;
            state_d   = S_LEN;
          end
        end
        S_LEN: begin
          frame_len_d = data_rx;
          cnt_d       = data_rx;
          state_d     = (data_rx == '0) ? S_ENDF : S_DATA;
        end
        S_DATA: begin
          // No escaping: a flag value here is ordinary payload
          data_d       = data_rx;
          data_valid_d = 1'b1;
          cnt_d        = cnt_q - BYTE_W'(1);
          if (cnt_q == BYTE_W'(1)) state_d = S_ENDF;
        end
        S_ENDF: begin
          if (is_flag_c) frame_done_d  = 1'b1;
          else           frame_error_d = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_IDLE) begin
      tmo_d = '0;
    end else if (timeout_hit_c) begin
      tmo_d         = '0;
      frame_error_d = 1'b1;
      state_d       = S_IDLE;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, synchronous reset aborts any frame silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tmo_q         <= '0;
      address_q     <= '0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      frame_len_q   <= '0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      address_q     <= address_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      frame_len_q   <= frame_len_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  assign address     = address_q;
  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign frame_len   = frame_len_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: byte-level vector table plus payload scoreboard,
// with hand-written timeout, byte-vs-timeout and mid-frame reset sequences.
module tb_uart_frame_parser;

  localparam int unsigned T = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_data_rx;
  logic [7:0] data_rx;
  logic [7:0] address, data, frame_len;
  logic       data_valid, frame_done, frame_error, busy;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] b;
    logic [7:0] addr;
    logic [7:0] len;
    logic       dv;
    logic       done;
    logic       err;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  uart_frame_parser #(.TIMEOUT_CYCLES(T), .FLAG(8'h7E)) dut (
    .clk(clk), .rst(rst), .new_data_rx(new_data_rx), .data_rx(data_rx),
    .address(address), .data(data), .data_valid(data_valid),
    .frame_len(frame_len), .frame_done(frame_done), .frame_error(frame_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Payload scoreboard and pulse exclusivity monitor
  always @(negedge clk) begin
    if (data_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL scoreboard: got data=%02h, want no payload byte", data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (data !== e) begin
          n_miss++;
          $display("FAIL scoreboard: got data=%02h, want %02h", data, e);
        end
      end
    end
    if ((frame_done && frame_error) || ((frame_done || frame_error) && data_valid)) begin
      n_miss++;
      $display("FAIL exclusive: done=%0b err=%0b dv=%0b", frame_done, frame_error, data_valid);
    end
  end

  function automatic vec_t mk(input logic [7:0] b, input logic [7:0] addr, input logic [7:0] len,
                              input logic dv, input logic done, input logic err, input logic bsy);
    vec_t v;
    v.b = b; v.addr = addr; v.len = len; v.dv = dv; v.done = done; v.err = err; v.busy = bsy;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    new_data_rx = 1'b1;
    data_rx     = b;
    @(negedge clk);
    new_data_rx = 1'b0;
    data_rx     = 8'h7E;  // unqualified flag value on the bus must be ignored
  endtask

  task automatic check_out(input string name, input vec_t e);
    n_vec++;
    if (address !== e.addr || frame_len !== e.len || data_valid !== e.dv ||
        (e.dv && data !== e.b) || frame_done !== e.done || frame_error !== e.err ||
        busy !== e.busy) begin
      n_miss++;
      $display("FAIL %s byte=%02h: got addr=%02h len=%02h dv=%0b d=%02h done=%0b err=%0b busy=%0b, want addr=%02h len=%02h dv=%0b d=%02h done=%0b err=%0b busy=%0b",
               name, e.b, address, frame_len, data_valid, data, frame_done, frame_error, busy,
               e.addr, e.len, e.dv, e.b, e.done, e.err, e.busy);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    if (v.dv) sb.push_back(v.b);
    send_byte(v.b);
    check_out(name, v);
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if (address !== 8'h00 || data !== 8'h00 || data_valid !== 1'b0 || frame_len !== 8'h00 ||
        frame_done !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL %s: got addr=%02h d=%02h dv=%0b len=%02h done=%0b err=%0b busy=%0b, want all 0",
               name, address, data, data_valid, frame_len, frame_done, frame_error, busy);
    end
  endtask

  initial begin
    int  k;
    bit  err_seen;

    // Test 1: 7E 00 04 AA 99 55 66 7E
    vecs.push_back(mk(8'h7E, 8'h00, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(8'h04, 8'h00, 8'h04, 0, 0, 0, 1));
    vecs.push_back(mk(8'hAA, 8'h00, 8'h04, 1, 0, 0, 1));
    vecs.push_back(mk(8'h99, 8'h00, 8'h04, 1, 0, 0, 1));
    vecs.push_back(mk(8'h55, 8'h00, 8'h04, 1, 0, 0, 1));
    vecs.push_back(mk(8'h66, 8'h00, 8'h04, 1, 0, 0, 1));
    vecs.push_back(mk(8'h7E, 8'h00, 8'h04, 0, 1, 0, 0));
    // Test 2: 7E 01 00 7E
    vecs.push_back(mk(8'h7E, 8'h00, 8'h04, 0, 0, 0, 1));
    vecs.push_back(mk(8'h01, 8'h01, 8'h04, 0, 0, 0, 1));
    vecs.push_back(mk(8'h00, 8'h01, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(8'h7E, 8'h01, 8'h00, 0, 1, 0, 0));
    // Test 3: 7E 00 03 7E 7E 02 7E
    vecs.push_back(mk(8'h7E, 8'h01, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(8'h03, 8'h00, 8'h03, 0, 0, 0, 1));
    vecs.push_back(mk(8'h7E, 8'h00, 8'h03, 1, 0, 0, 1));
    vecs.push_back(mk(8'h7E, 8'h00, 8'h03, 1, 0, 0, 1));
    vecs.push_back(mk(8'h02, 8'h00, 8'h03, 1, 0, 0, 1));
    vecs.push_back(mk(8'h7E, 8'h00, 8'h03, 0, 1, 0, 0));
    // Test 4: 7E 00 02 BB CC 55, then 7E 03 01 5A 7E
    vecs.push_back(mk(8'h7E, 8'h00, 8'h03, 0, 0, 0, 1));
    vecs.push_back(mk(8'h00, 8'h00, 8'h03, 0, 0, 0, 1));
    vecs.push_back(mk(8'h02, 8'h00, 8'h02, 0, 0, 0, 1));
    vecs.push_back(mk(8'hBB, 8'h00, 8'h02, 1, 0, 0, 1));
    vecs.push_back(mk(8'hCC, 8'h00, 8'h02, 1, 0, 0, 1));
    vecs.push_back(mk(8'h55, 8'h00, 8'h02, 0, 0, 1, 0));
    vecs.push_back(mk(8'h7E, 8'h00, 8'h02, 0, 0, 0, 1));
    vecs.push_back(mk(8'h03, 8'h03, 8'h02, 0, 0, 0, 1));
    vecs.push_back(mk(8'h01, 8'h03, 8'h01, 0, 0, 0, 1));
    vecs.push_back(mk(8'h5A, 8'h03, 8'h01, 1, 0, 0, 1));
    vecs.push_back(mk(8'h7E, 8'h03, 8'h01, 0, 1, 0, 0));
    // Test 6: garbage 12 34, then 7E 7E 7E 05 01 DE 7E
    vecs.push_back(mk(8'h12, 8'h03, 8'h01, 0, 0, 0, 0));
    vecs.push_back(mk(8'h34, 8'h03, 8'h01, 0, 0, 0, 0));
    vecs.push_back(mk(8'h7E, 8'h03, 8'h01, 0, 0, 0, 1));
    vecs.push_back(mk(8'h7E, 8'h03, 8'h01, 0, 0, 0, 1));
    vecs.push_back(mk(8'h7E, 8'h03, 8'h01, 0, 0, 0, 1));
    vecs.push_back(mk(8'h05, 8'h05, 8'h01, 0, 0, 0, 1));
    vecs.push_back(mk(8'h01, 8'h05, 8'h01, 0, 0, 0, 1));
    vecs.push_back(mk(8'hDE, 8'h05, 8'h01, 1, 0, 0, 1));
    vecs.push_back(mk(8'h7E, 8'h05, 8'h01, 0, 1, 0, 0));

    rst         = 1'b1;
    new_data_rx = 1'b0;
    data_rx     = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Test 5: inter-byte timeout, error exactly T cycles after the last byte
    apply("tmo_flag", mk(8'h7E, 8'h05, 8'h01, 0, 0, 0, 1));
    apply("tmo_addr", mk(8'h00, 8'h00, 8'h01, 0, 0, 0, 1));
    apply("tmo_len",  mk(8'h05, 8'h00, 8'h05, 0, 0, 0, 1));
    apply("tmo_d0",   mk(8'h11, 8'h00, 8'h05, 1, 0, 0, 1));
    apply("tmo_d1",   mk(8'h22, 8'h00, 8'h05, 1, 0, 0, 1));
    k = 0;
    while (k < 2 * int'(T)) begin
      @(negedge clk);
      k++;
      if (frame_error) break;
    end
    n_vec++;
    if (!frame_error || k != int'(T)) begin
      n_miss++;
      $display("FAIL timeout_latency: got error=%0b after %0d cycles, want error after %0d cycles",
               frame_error, k, T);
    end
    @(negedge clk);
    check_zero_busy: begin
      n_vec++;
      if (busy !== 1'b0 || frame_error !== 1'b0) begin
        n_miss++;
        $display("FAIL timeout_idle: got busy=%0b err=%0b, want busy=0 err=0", busy, frame_error);
      end
    end

    // Byte arriving on the cycle the timeout would fire wins
    apply("race_flag", mk(8'h7E, 8'h00, 8'h05, 0, 0, 0, 1));
    apply("race_addr", mk(8'h00, 8'h00, 8'h05, 0, 0, 0, 1));
    apply("race_len",  mk(8'h05, 8'h00, 8'h05, 0, 0, 0, 1));
    apply("race_d0",   mk(8'h11, 8'h00, 8'h05, 1, 0, 0, 1));
    repeat (T - 2) @(negedge clk);
    apply("race_d1",   mk(8'h22, 8'h00, 8'h05, 1, 0, 0, 1));

    // Reset mid-frame: everything clears and no error pulse follows
    rst = 1'b1;
    @(negedge clk);
    check_zero("midframe_reset");
    @(negedge clk);
    rst = 1'b0;
    err_seen = 1'b0;
    repeat (T + 5) begin
      @(negedge clk);
      if (frame_error || busy) err_seen = 1'b1;
    end
    n_vec++;
    if (err_seen) begin
      n_miss++;
      $display("FAIL post_reset_quiet: got error/busy activity after reset, want none");
    end
    check_zero("post_reset_state");

    // Clean frame after the reset
    apply("rec_flag",  mk(8'h7E, 8'h00, 8'h00, 0, 0, 0, 1));
    apply("rec_addr",  mk(8'h09, 8'h09, 8'h00, 0, 0, 0, 1));
    apply("rec_len",   mk(8'h00, 8'h09, 8'h00, 0, 0, 0, 1));
    apply("rec_close", mk(8'h7E, 8'h09, 8'h00, 0, 1, 0, 0));

    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d bytes still expected, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
